// File: rtl/hc595_driver_if.sv
// Bus bundle between the segment decoders and the 74HC595 pin driver.
// The master modport is the driver side; the slave modport is the code source or pin observer.
interface hc595_driver_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [8*NUM_DIGITS-1:0] seg_data;
    logic                    ser;
    logic                    srclk;
    logic                    rclk;
    logic                    busy;
    logic                    frame_done;
    logic [2:0]              digit_idx;

    modport master (
        input  seg_data,
        output ser,
        output srclk,
        output rclk,
        output busy,
        output frame_done,
        output digit_idx
    );

    modport slave (
        output seg_data,
        input  ser,
        input  srclk,
        input  rclk,
        input  busy,
        input  frame_done,
        input  digit_idx
    );
endinterface

// File: rtl/hc595_driver.sv
// Time-multiplexed seven-segment driver for two cascaded 74HC595s (SER/SRCLK/RCLK).
// Optional OE brightness PWM is enabled by defining HC595_OE_PWM_EN.
module hc595_driver #(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned REFRESH_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
`ifdef HC595_OE_PWM_EN
    input  logic [3:0] brightness_i,
    output logic       oe_n_o,
`endif
    hc595_driver_if.master bus_io
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    localparam int unsigned RefW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [RefW-1:0] RefLast   = RefW'(REFRESH_CYCLES - 1);
    localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [2:0]      DigitLast = 3'(NUM_DIGITS - 1);

    logic [1:0]      state_q, state_d;
    logic [RefW-1:0] ref_q, ref_d;
    logic            pend_q, pend_d;
    logic [DivW-1:0] div_q, div_d;
    logic            phase_q, phase_d;
    logic [3:0]      bit_q, bit_d;
    logic [15:0]     shreg_q, shreg_d;
    logic            ser_q, ser_d;
    logic [2:0]      digit_q, digit_d;
    logic            fd_q, fd_d;
    logic            srclk_q, srclk_d;
    logic            rclk_q, rclk_d;
    logic            busy_q, busy_d;
    logic            tick;
    logic [7:0]      seg_byte, sel_byte;

    always_comb begin
        tick     = (ref_q == RefLast);
        ref_d    = tick ? '0 : ref_q + 1'b1;
        seg_byte = bus_io.seg_data[{digit_q, 3'b000} +: 8];
        sel_byte = ~(8'd1 << digit_q);

        state_d = state_q;
        pend_d  = pend_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ser_d   = ser_q;
        digit_d = digit_q;
        fd_d    = 1'b0;

        // A tick during a transfer is remembered and served on return to idle.
        if (tick && state_q != ST_IDLE) pend_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (tick || pend_q) begin
                    state_d = ST_LOAD;
                    pend_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                shreg_d = {seg_byte, sel_byte};
                ser_d   = seg_byte[7];
                bit_d   = 4'd15;
                div_d   = '0;
                phase_d = 1'b0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == 4'd0) begin
                        phase_d = 1'b0;
                        state_d = ST_LATCH;
                    end else begin
                        // Next bit is presented as SRCLK falls, ahead of its rising edge.
                        phase_d = 1'b0;
                        bit_d   = bit_q - 4'd1;
                        shreg_d = {shreg_q[14:0], 1'b0};
                        ser_d   = shreg_q[14];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_LATCH: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                    fd_d    = 1'b1;
                    digit_d = (digit_q == DigitLast) ? 3'd0 : digit_q + 3'd1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        srclk_d = (state_d == ST_SHIFT) && phase_d;
        rclk_d  = (state_d == ST_LATCH);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ref_q   <= '0;
            pend_q  <= 1'b0;
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= 4'd0;
            shreg_q <= 16'd0;
            ser_q   <= 1'b0;
            digit_q <= 3'd0;
            fd_q    <= 1'b0;
            srclk_q <= 1'b0;
            rclk_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            pend_q  <= pend_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ser_q   <= ser_d;
            digit_q <= digit_d;
            fd_q    <= fd_d;
            srclk_q <= srclk_d;
            rclk_q  <= rclk_d;
            busy_q  <= busy_d;
        end
    end

    assign bus_io.ser        = ser_q;
    assign bus_io.srclk      = srclk_q;
    assign bus_io.rclk       = rclk_q;
    assign bus_io.busy       = busy_q;
    assign bus_io.frame_done = fd_q;
    assign bus_io.digit_idx  = digit_q;

`ifdef HC595_OE_PWM_EN
    logic [3:0] pwm_q;
    logic       oe_n_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pwm_q  <= 4'd0;
            oe_n_q <= 1'b1;
        end else begin
            pwm_q  <= pwm_q + 4'd1;
            oe_n_q <= ~(pwm_q < brightness_i);
        end
    end

    assign oe_n_o = oe_n_q;
`endif
endmodule

// File: tb/tb_hc595_driver.sv
// Directed bench for hc595_driver: reset, single transfer, digit wrap, snapshot, mid-transfer reset.
module tb_hc595_driver;
    localparam int unsigned ND = 4;
    localparam int unsigned CD = 2;
    localparam int unsigned RC = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hc595_driver_if #(.NUM_DIGITS(ND)) ifc ();

`ifdef HC595_OE_PWM_EN
    logic [3:0] brightness;
    logic       oe_n;
`endif

    hc595_driver #(
        .NUM_DIGITS    (ND),
        .CLK_DIV       (CD),
        .REFRESH_CYCLES(RC)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
`ifdef HC595_OE_PWM_EN
        .brightness_i(brightness),
        .oe_n_o      (oe_n),
`endif
        .bus_io      (ifc)
    );

    int errors = 0;
    int checks = 0;

    // Pin observers: bits captured at SRCLK rising edges, and per-cycle activity counts.
    logic [15:0] cap = 16'd0;
    int srclk_edges = 0;
    int busy_cyc = 0;
    int rclk_cyc = 0;
    int fd_cnt = 0;

    always @(posedge ifc.srclk) begin
        cap         <= {cap[14:0], ifc.ser};
        srclk_edges <= srclk_edges + 1;
    end

    always @(posedge clk) begin
        if (ifc.busy === 1'b1) busy_cyc <= busy_cyc + 1;
        if (ifc.rclk === 1'b1) rclk_cyc <= rclk_cyc + 1;
        if (ifc.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * RC; i++) begin
            cyc(1);
            if (ifc.frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_busy(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * RC; i++) begin
            cyc(1);
            if (ifc.busy === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int b0, e0, r0, f0, e_cnt;

    initial begin
        ifc.seg_data = {8'hfd, 8'hfd, 8'hfd, 8'h03};
`ifdef HC595_OE_PWM_EN
        brightness = 4'd4;
`endif
        rst_n = 1'b0;
        cyc(5);
        chk("rst_ser", 32'(ifc.ser), 32'd0);
        chk("rst_srclk", 32'(ifc.srclk), 32'd0);
        chk("rst_rclk", 32'(ifc.rclk), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_frame_done", 32'(ifc.frame_done), 32'd0);
        chk("rst_digit_idx", 32'(ifc.digit_idx), 32'd0);
`ifdef HC595_OE_PWM_EN
        chk("rst_oe_n", 32'(oe_n), 32'd1);
`endif

        // Refresh counter reaches RC-1 after RC-1 edges; LOAD follows on the next edge.
        rst_n = 1'b1;
        b0 = busy_cyc;
        e0 = srclk_edges;
        r0 = rclk_cyc;
        f0 = fd_cnt;
        cyc(RC - 1);
        chk("idle_before_tick", 32'(ifc.busy), 32'd0);
        cyc(1);
        chk("load_after_tick", 32'(ifc.busy), 32'd1);

        wait_frame("frame0_seen");
        chk("frame0_word", 32'(cap), 32'h03fe);
        chk("frame0_srclk_edges", 32'(srclk_edges - e0), 32'd16);
        chk("frame0_rclk_cycles", 32'(rclk_cyc - r0), 32'd2);
        chk("frame0_busy_low", 32'(ifc.busy), 32'd0);
        chk("frame0_digit_idx", 32'(ifc.digit_idx), 32'd1);
        cyc(1);
        chk("frame0_busy_cycles", 32'(busy_cyc - b0), 32'd67);
        chk("frame0_done_pulses", 32'(fd_cnt - f0), 32'd1);
        chk("frame0_done_width", 32'(ifc.frame_done), 32'd0);

        // Wrap across all four digits.
        ifc.seg_data = {8'h9f, 8'h25, 8'h0d, 8'h09};
        wait_frame("wrap_d1_seen");
        chk("wrap_d1_word", 32'(cap), 32'h0dfd);
        chk("wrap_d1_idx", 32'(ifc.digit_idx), 32'd2);
        wait_frame("wrap_d2_seen");
        chk("wrap_d2_word", 32'(cap), 32'h25fb);
        chk("wrap_d2_idx", 32'(ifc.digit_idx), 32'd3);
        wait_frame("wrap_d3_seen");
        chk("wrap_d3_word", 32'(cap), 32'h9ff7);
        chk("wrap_d3_idx", 32'(ifc.digit_idx), 32'd0);
        wait_frame("wrap_d0_seen");
        chk("wrap_d0_word", 32'(cap), 32'h09fe);
        chk("wrap_d0_idx", 32'(ifc.digit_idx), 32'd1);

        // Snapshot: digit 1 changes from 03 to 01 during its SHIFT.
        ifc.seg_data[15:8] = 8'h03;
        wait_busy("snap_busy_seen");
        cyc(10);
        ifc.seg_data[15:8] = 8'h01;
        wait_frame("snap_seen");
        chk("snap_word_old", 32'(cap), 32'h03fd);
        wait_frame("snap_d2_seen");
        wait_frame("snap_d3_seen");
        wait_frame("snap_d0_seen");
        wait_frame("snap_next_seen");
        chk("snap_word_new", 32'(cap), 32'h01fd);
        chk("snap_idx", 32'(ifc.digit_idx), 32'd2);

        // Reset while bit 7 is on the wire (after 9 SRCLK rising edges of this transfer).
        wait_busy("mid_busy_seen");
        e0 = srclk_edges;
        e_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (srclk_edges - e0 >= 9) break;
            cyc(1);
            e_cnt++;
        end
        chk("mid_reached_bit7", 32'(srclk_edges - e0), 32'd9);
        chk("mid_still_busy", 32'(ifc.busy), 32'd1);
        rst_n = 1'b0;
        r0 = rclk_cyc;
        f0 = fd_cnt;
        cyc(1);
        chk("mid_rst_srclk", 32'(ifc.srclk), 32'd0);
        chk("mid_rst_busy", 32'(ifc.busy), 32'd0);
        chk("mid_rst_digit_idx", 32'(ifc.digit_idx), 32'd0);
        chk("mid_rst_rclk", 32'(ifc.rclk), 32'd0);
        rst_n = 1'b1;
        cyc(20);
        chk("mid_no_rclk", 32'(rclk_cyc - r0), 32'd0);
        chk("mid_no_frame_done", 32'(fd_cnt - f0), 32'd0);
        wait_frame("restart_seen");
        chk("restart_word", 32'(cap), 32'h09fe);
        chk("restart_idx", 32'(ifc.digit_idx), 32'd1);

`ifdef HC595_OE_PWM_EN
        begin
            int lows;
            lows = 0;
            for (int i = 0; i < 16; i++) begin
                cyc(1);
                if (oe_n === 1'b0) lows++;
            end
            chk("pwm_b4_low_cycles", 32'(lows), 32'd4);
            brightness = 4'd0;
            cyc(2);
            lows = 0;
            for (int i = 0; i < 32; i++) begin
                cyc(1);
                if (oe_n !== 1'b1) lows++;
            end
            chk("pwm_b0_low_cycles", 32'(lows), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
